// File: rtl/fb_pixel_source.sv
// Framebuffer-backed pixel source: scaled RGB444 framebuffer read in the active region,
// written from a small queue (or bulk-filled) only during blanking.
module fb_pixel_source #(
    parameter int unsigned WIDTH       = 800,
    parameter int unsigned HEIGHT      = 600,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] pix_x,
    input  logic [15:0] pix_y,
    output logic [15:0] color,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [11:0] wr_color,
    input  logic        clear_req,
    input  logic [11:0] clear_color,
    output logic        clear_busy
);
    localparam int unsigned FbW   = WIDTH >> SCALE_SHIFT;
    localparam int unsigned FbH   = HEIGHT >> SCALE_SHIFT;
    localparam int unsigned FbN   = FbW * FbH;
    localparam int unsigned AddrW = $clog2(FbN);
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e           state_q;
    logic             clear_busy_q;
    logic [AddrW-1:0] clr_addr_q;
    logic [11:0]      clear_color_q;

    logic [27:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_ready_q;

    logic [11:0]      mem [FbN];
    logic [11:0]      rd_q;
    logic             act_q;
    logic [15:0]      color_q;

    logic             active, push, pop, head_in_range;
    logic [7:0]       head_x, head_y;
    logic [11:0]      head_color;
    logic [AddrW-1:0] rd_addr, head_addr, ram_addr;
    logic             ram_we;
    logic [11:0]      ram_wdata;

    assign active = ({16'd0, pix_x} < WIDTH) && ({16'd0, pix_y} < HEIGHT);
    assign rd_addr = AddrW'(({16'd0, pix_y} >> SCALE_SHIFT) * FbW
                            + ({16'd0, pix_x} >> SCALE_SHIFT));

    assign {head_x, head_y, head_color} = fifo_q[rd_ptr_q];
    assign head_in_range = ({24'd0, head_x} < FbW) && ({24'd0, head_y} < FbH);
    assign head_addr     = AddrW'({24'd0, head_y} * FbW + {24'd0, head_x});

    // The registered term resets to 1 (empty queue); res masks it while held in reset.
    assign wr_ready = wr_ready_q & res;
    assign push     = wr_valid & wr_ready;
    assign pop      = (state_q == StDrain) & ~active & (count_q != '0) & res;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Single RAM port: a blanking write wins, otherwise the active pixel is read.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = clear_color_q;
        if (res && !active) begin
            if (state_q == StClear) begin
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
            end else if (pop && head_in_range) begin
                ram_we    = 1'b1;
                ram_addr  = head_addr;
                ram_wdata = head_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (active) begin
            rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {wr_x, wr_y, wr_color};
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q       <= StIdle;
            clear_busy_q  <= 1'b0;
            clr_addr_q    <= '0;
            clear_color_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wr_ready_q    <= 1'b1;
            act_q         <= 1'b0;
            color_q       <= '0;
        end else begin
            count_q    <= count_d;
            wr_ready_q <= (count_d < CntW'(FIFO_DEPTH));
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            act_q   <= active;
            color_q <= act_q ? {4'h0, rd_q} : 16'h0000;

            case (state_q)
                StIdle, StDrain: begin
                    if (clear_req) begin
                        state_q       <= StClear;
                        clear_busy_q  <= 1'b1;
                        clr_addr_q    <= '0;
                        clear_color_q <= clear_color;
                    end else if (state_q == StIdle && count_q != '0) begin
                        state_q <= StDrain;
                    end else if (state_q == StDrain && count_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                StClear: begin
                    if (!active) begin
                        if (clr_addr_q == AddrW'(FbN - 1)) begin
                            state_q      <= StIdle;
                            clear_busy_q <= 1'b0;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign color      = color_q;
    assign clear_busy = clear_busy_q;

endmodule
